hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_counter.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard definitions: decoder destination-source codes and FSM state encodings.
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`define DEST_SRC_NONE 2'd0
`define DEST_SRC_ALU 2'd1
`define DEST_SRC_MEM 2'd2
`endif

package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_ST_RUN   = 2'd0,
    SB_ST_DRAIN = 2'd1,
    SB_ST_DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: saturating per-register in-flight write counter; flags under/overflow instead of wrapping.
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic empty_nxt,
  output logic err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;

  // Simultaneous inc and dec cancel; an illegal step holds the count and raises err.
  always_comb begin
    cnt_nxt = cnt_r;
    err     = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (cnt_r == CNT_MAX) err = 1'b1;
        else                  cnt_nxt = cnt_r + CNT_ONE;
      end
      2'b01: begin
        if (cnt_r == CNT_ZERO) err = 1'b1;
        else                   cnt_nxt = cnt_r - CNT_ONE;
      end
      default: cnt_nxt = cnt_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_r <= CNT_ZERO;
    else     cnt_r <= cnt_nxt;
  end

  assign busy      = (cnt_r != CNT_ZERO);
  assign full      = (cnt_r == CNT_MAX);
  assign empty_nxt = (cnt_nxt == CNT_ZERO);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard with RAW stall and drain FSM.
// Define SCOREBOARD_FWD_EN to track only MEM writers (ALU results are forwarded).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_CNT = 32,
  parameter int CNT_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             id_rd,
  input  logic [`DEST_SRC_W-1:0] id_dest_src,
  input  logic                   id_flush,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   drain_req,
  output logic                   id_ready,
  output logic                   issue,
  output logic                   drain_done,
  output logic                   sb_err
);

  sb_state_e        state;
  sb_state_e        state_nxt;
  logic             tracked;
  logic             raw_hazard;
  logic             full_hazard;
  logic             enter_done;
  logic [REG_CNT-1:0] busy;
  logic [REG_CNT-1:0] full;
  logic [REG_CNT-1:0] empty_nxt;
  logic [REG_CNT-1:0] err_v;

  always_comb begin
`ifdef SCOREBOARD_FWD_EN
    tracked = (id_dest_src == `DEST_SRC_MEM);
`else
    tracked = (id_dest_src == `DEST_SRC_ALU) || (id_dest_src == `DEST_SRC_MEM);
`endif
  end

  // x0 is never tracked, so its slot reads as permanently empty.
  assign busy[0]      = 1'b0;
  assign full[0]      = 1'b0;
  assign empty_nxt[0] = 1'b1;
  assign err_v[0]     = 1'b0;

  for (genvar i = 1; i < REG_CNT; i++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue && tracked && (id_rd == 5'(i))),
      .dec       (wb_valid && (wb_rd == 5'(i))),
      .busy      (busy[i]),
      .full      (full[i]),
      .empty_nxt (empty_nxt[i]),
      .err       (err_v[i])
    );
  end

  // Hazards use registered counts, so a same-cycle retire never releases a stall.
  always_comb begin
    raw_hazard  = (id_use_rs1 && busy[id_rs1]) || (id_use_rs2 && busy[id_rs2]);
    full_hazard = tracked && full[id_rd];
    id_ready    = (state == SB_ST_RUN) && !raw_hazard && !full_hazard;
    issue       = id_valid && id_ready && !id_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SB_ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    case (state)
      SB_ST_RUN: begin
        if (drain_req) state_nxt = SB_ST_DRAIN;
        else           state_nxt = SB_ST_RUN;
      end
      SB_ST_DRAIN: begin
        if (&empty_nxt) begin
          state_nxt  = SB_ST_DONE;
          enter_done = 1'b1;
        end else begin
          state_nxt  = SB_ST_DRAIN;
        end
      end
      SB_ST_DONE: begin
        if (!drain_req) state_nxt = SB_ST_RUN;
        else            state_nxt = SB_ST_DONE;
      end
      default: state_nxt = SB_ST_RUN;
    endcase
  end

  // drain_done is high only for the first cycle in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_done <= 1'b0;
      sb_err     <= 1'b0;
    end else begin
      drain_done <= enter_done;
      sb_err     <= sb_err | (|err_v);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic vs. a counting model.
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`define DEST_SRC_NONE 2'd0
`define DEST_SRC_ALU 2'd1
`define DEST_SRC_MEM 2'd2
`endif

module tb_hazard_scoreboard;

  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_rs1, id_use_rs2, id_flush, wb_valid, drain_req;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [`DEST_SRC_W-1:0] id_dest_src;
  logic id_ready, issue, drain_done, sb_err;

  int checks = 0;
  int errors = 0;
  int m_cnt [32];
  bit m_err;

  hazard_scoreboard #(.REG_CNT(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_dest_src(id_dest_src), .id_flush(id_flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .drain_req(drain_req), .id_ready(id_ready), .issue(issue),
    .drain_done(drain_done), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_tracked(input logic [1:0] ds);
`ifdef SCOREBOARD_FWD_EN
    return ds == `DEST_SRC_MEM;
`else
    return (ds == `DEST_SRC_ALU) || (ds == `DEST_SRC_MEM);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_dest_src = `DEST_SRC_NONE; id_flush = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; drain_req = 1'b0;
  endtask

  task automatic present(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic [1:0] ds);
    id_valid = 1'b1; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_dest_src = ds; id_flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    wb_valid = 1'b0; drain_req = 1'b1;
    tick();
    drain_req = 1'b0; rst = 1'b1;
    tick();
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done got %b exp 0", drain_done); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b exp 1", id_ready); end
    rst = 1'b0;
    tick();
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL post_reset_id_ready got %b exp 1", id_ready); end
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_no_pulse got %b exp 0", drain_done); end
  endtask

  task automatic test_raw_mem();
    do_reset();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, `DEST_SRC_MEM);
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_producer_issue got %b exp 1", issue); end
    tick();
    present(5'd5, 1'b1, 5'd0, 1'b0, 5'd1, `DEST_SRC_NONE);
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %b exp 0", id_ready); end
    tick();
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL raw_stall2_issue got %b exp 0", issue); end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_same_cycle_retire got %b exp 0", id_ready); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", id_ready); end
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL raw_release_issue got %b exp 1", issue); end
    tick();
    idle();
  endtask

  task automatic test_alu_writer();
    bit exp_stall;
`ifdef SCOREBOARD_FWD_EN
    exp_stall = 1'b0;
`else
    exp_stall = 1'b1;
`endif
    do_reset();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, `DEST_SRC_ALU);
    tick();
    present(5'd0, 1'b0, 5'd5, 1'b1, 5'd1, `DEST_SRC_NONE);
    #1;
    checks++; if (id_ready !== !exp_stall) begin errors++; $display("FAIL alu_consumer_ready got %b exp %b", id_ready, !exp_stall); end
    if (exp_stall) begin
      wb_valid = 1'b1; wb_rd = 5'd5;
      tick();
      wb_valid = 1'b0;
    end
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL alu_after ready got %b exp 1", id_ready); end
    tick();
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL alu_sb_err got %b exp 0", sb_err); end
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, `DEST_SRC_MEM);
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL x0_writer_issue%0d got %b exp 1", k, issue); end
      tick();
    end
    present(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, `DEST_SRC_MEM);
    wb_valid = 1'b1; wb_rd = 5'd0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL x0_consumer_ready got %b exp 1", id_ready); end
    tick();
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL x0_sb_err got %b exp 0", sb_err); end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, `DEST_SRC_MEM);
      #1;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_issue%0d got %b exp 1", k, issue); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL sat_fourth_stall got %b exp 0", id_ready); end
    tick();
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_inc_dec_issue got %b exp 1", issue); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL sat_refill_issue got %b exp 1", issue); end
    tick();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL sat_full_again got %b exp 0", id_ready); end
    idle();
    wb_valid = 1'b1; wb_rd = 5'd7;
    for (int k = 0; k < 3; k++) tick();
    wb_valid = 1'b0;
    present(5'd7, 1'b1, 5'd7, 1'b1, 5'd0, `DEST_SRC_NONE);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL sat_drained_ready got %b exp 1", id_ready); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err got %b exp 0", sb_err); end
    tick();
    idle();
  endtask

  task automatic test_err();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    wb_valid = 1'b0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 0->1", sb_err); end
    present(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, `DEST_SRC_NONE);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL err_cnt_stays0 got %b exp 1", id_ready); end
    idle();
    for (int k = 0; k < 3; k++) tick();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", sb_err); end
    do_reset();
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", sb_err); end
  endtask

  task automatic test_flush();
    do_reset();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, `DEST_SRC_MEM);
    id_flush = 1'b1;
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_issue got %b exp 0", issue); end
    tick();
    present(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, `DEST_SRC_MEM);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_no_inc got %b exp 1", id_ready); end
    tick();
    present(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, `DEST_SRC_NONE);
    id_flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6;
    #1;
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL flush_retire_issue got %b exp 0", issue); end
    tick();
    id_flush = 1'b0; wb_valid = 1'b0;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_retire_dec got %b exp 1", id_ready); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL flush_sb_err got %b exp 0", sb_err); end
    tick();
    idle();
  endtask

  task automatic test_drain();
    do_reset();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, `DEST_SRC_MEM);
    tick();
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, `DEST_SRC_MEM);
    tick();
    present(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, `DEST_SRC_NONE);
    drain_req = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL drain_req_cycle_ready got %b exp 1", id_ready); end
    tick();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL drain_ready got %b exp 0", id_ready); end
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_early_pulse got %b exp 0", drain_done); end
    wb_rd = 5'd4;
    tick();
    wb_valid = 1'b0;
    checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL drain_pulse got %b exp 1", drain_done); end
    tick();
    checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL drain_single_pulse got %b exp 0", drain_done); end
    drain_req = 1'b0;
    tick();
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL drain_back_run got %b exp 1", id_ready); end
    // Drain requested while already empty still spends one cycle in DRAIN.
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    checks++; if (drain_done !== 1'b0 || id_ready !== 1'b0) begin errors++; $display("FAIL empty_drain_c1 got done=%b ready=%b exp 0/0", drain_done, id_ready); end
    tick();
    checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL empty_drain_pulse got %b exp 1", drain_done); end
    tick();
    checks++; if (drain_done !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL empty_drain_c3 got done=%b ready=%b exp 0/1", drain_done, id_ready); end
    // Reset in the middle of a drain.
    present(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, `DEST_SRC_MEM);
    tick();
    idle();
    drain_req = 1'b1;
    tick();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rst_drain_ready got %b exp 0", id_ready); end
    drain_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL rst_drain_pulse%0d got %b exp 0", k, drain_done); end
      tick();
    end
    present(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, `DEST_SRC_NONE);
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_run got %b exp 1", id_ready); end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [4:0] r1, r2, rd, wr;
    logic u1, u2, v, fl, wv;
    logic [1:0] ds;
    bit trk, exp_ready, exp_issue, inc, dec;
    do_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      v  = 1'($urandom_range(0, 1));
      r1 = 5'($urandom_range(0, 7)); u1 = 1'($urandom_range(0, 1));
      r2 = 5'($urandom_range(0, 7)); u2 = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 7)); ds = 2'($urandom_range(0, 2));
      fl = ($urandom_range(0, 7) == 0);
      wr = 5'($urandom_range(1, 7));
      wv = ($urandom_range(0, 1) == 1) && ((m_cnt[wr] > 0) || ($urandom_range(0, 31) == 0));
      present(r1, u1, r2, u2, rd, ds);
      id_valid = v; id_flush = fl; wb_valid = wv; wb_rd = wr;
      trk = is_tracked(ds);
      exp_ready = !((u1 && r1 != 0 && m_cnt[r1] > 0) || (u2 && r2 != 0 && m_cnt[r2] > 0) ||
                    (trk && rd != 0 && m_cnt[rd] == MAXC));
      exp_issue = v && exp_ready && !fl;
      #1;
      checks++; if (id_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, id_ready, exp_ready); end
      checks++; if (issue !== exp_issue) begin errors++; $display("FAIL rnd_issue cyc %0d got %b exp %b", c, issue, exp_issue); end
      inc = exp_issue && trk && rd != 0;
      dec = wv && wr != 0;
      if (!(inc && dec && rd == wr)) begin
        if (inc) begin
          if (m_cnt[rd] == MAXC) m_err = 1'b1;
          else m_cnt[rd]++;
        end
        if (dec) begin
          if (m_cnt[wr] == 0) m_err = 1'b1;
          else m_cnt[wr]--;
        end
      end
      tick();
      checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rnd_sb_err cyc %0d got %b exp %b", c, sb_err, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_raw_mem();
    test_alu_writer();
    test_x0();
    test_saturate();
    test_err();
    test_flush();
    test_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
